reg_file_2r1w: RTL

- Architectural integer register file: 32 x 32-bit, x0 hardwired to zero.
- Services the operand-read requests issued by the instruction-decode stage (RE, RD1_addr, RD2_addr → RD1, RD2).
- Accepts the write-back requests from the same decode/write-back path (WE, RW_addr, WR1).
- Reads are registered with 1-cycle latency and same-cycle write-to-read forwarding, so a decode stage sampling RD1/RD2 one cycle after RE always sees the newest value.

---
 rtl/reg_file_2r1w.sv | 100 ++++++++++
 1 files changed

// File: rtl/reg_file_2r1w.sv
// Architectural integer register file: NREGS x DATA_W, x0 hardwired to zero.
// Two registered read ports with write-to-read forwarding, one write port, and a combinational debug peek.
module reg_file_2r1w #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NREGS  = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              RE,
    input  logic [ADDR_W-1:0] RD1_addr,
    input  logic [ADDR_W-1:0] RD2_addr,
    input  logic              WE,
    input  logic [ADDR_W-1:0] RW_addr,
    input  logic [DATA_W-1:0] WR1,
    output logic [DATA_W-1:0] RD1,
    output logic [DATA_W-1:0] RD2,
    output logic              RD_valid,
    input  logic [ADDR_W-1:0] dbg_addr,
    output logic [DATA_W-1:0] dbg_data
);

    localparam logic [ADDR_W-1:0] ZERO_IDX = {ADDR_W{1'b0}};
    localparam logic [DATA_W-1:0] ZERO_DATA = {DATA_W{1'b0}};

    logic [DATA_W-1:0] regs_r [NREGS];
    logic              wr_en_s;
    logic [DATA_W-1:0] rd1_nxt_s;
    logic [DATA_W-1:0] rd2_nxt_s;

    // Newest value of a register as seen at this edge: x0 is zero, a same-edge write wins over the array.
    function automatic logic [DATA_W-1:0] read_fwd(
        input logic [ADDR_W-1:0] addr,
        input logic              we,
        input logic [ADDR_W-1:0] waddr,
        input logic [DATA_W-1:0] wdata,
        input logic [DATA_W-1:0] stored
    );
        logic [DATA_W-1:0] val;
        if (addr == ZERO_IDX) begin
            val = ZERO_DATA;
        end else if (we && (waddr == addr)) begin
            val = wdata;
        end else begin
            val = stored;
        end
        return val;
    endfunction

    // Write qualifier: writes to x0 are dropped so regs_r[0] never leaves its reset value.
    always_comb begin
        wr_en_s = WE && (RW_addr != ZERO_IDX);
    end

    // Next read-port values including forwarding.
    always_comb begin
        rd1_nxt_s = read_fwd(RD1_addr, WE, RW_addr, WR1, regs_r[RD1_addr]);
        rd2_nxt_s = read_fwd(RD2_addr, WE, RW_addr, WR1, regs_r[RD2_addr]);
    end

    // Register array storage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_r[i] <= ZERO_DATA;
            end
        end else if (wr_en_s) begin
            regs_r[RW_addr] <= WR1;
        end else begin
            regs_r[RW_addr] <= regs_r[RW_addr];
        end
    end

    // Registered read ports; data holds when no read is requested.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            RD1      <= ZERO_DATA;
            RD2      <= ZERO_DATA;
            RD_valid <= 1'b0;
        end else if (RE) begin
            RD1      <= rd1_nxt_s;
            RD2      <= rd2_nxt_s;
            RD_valid <= 1'b1;
        end else begin
            RD1      <= RD1;
            RD2      <= RD2;
            RD_valid <= 1'b0;
        end
    end

    // Debug peek reads the array only; regs_r[0] is always zero, the guard just makes that explicit.
    always_comb begin
        if (dbg_addr == ZERO_IDX) begin
            dbg_data = ZERO_DATA;
        end else begin
            dbg_data = regs_r[dbg_addr];
        end
    end

endmodule
